// File: rtl/spi_controller_tx_if.sv
// Command-side bundle for the SPI write controller: valid/ready handshake
// plus the busy/done status the host watches while a frame is in flight.
interface spi_controller_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       busy;
  logic       done;

  // Host side issues commands and watches status
  modport master (
    output cmd_valid, cmd_addr, cmd_data,
    input  cmd_ready, busy, done
  );

  // Controller side accepts commands and reports status
  modport slave (
    input  cmd_valid, cmd_addr, cmd_data,
    output cmd_ready, busy, done
  );
endinterface

// File: rtl/spi_controller_tx.sv
// SPI mode-0 write controller. Each accepted command becomes one 16-bit
// MSB-first frame {1'b1, addr[6:0], data[7:0]} on SCLK/COPI/nCS, followed by
// a chip-select gap before the next command can be taken.
module spi_controller_tx #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_controller_tx_if.slave  cmd,
  output logic                spi_sclk,
  output logic                spi_copi,
  output logic                spi_ncs
);

  localparam int DIV_W = $clog2(HALF_PERIOD + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             sclk_q, sclk_d;

  logic ready;
  logic accept;
  logic div_end;
  logic frame_active;

  assign ready        = (state_q == S_IDLE) && !rst;
  assign accept       = cmd.cmd_valid && ready;
  assign div_end      = (div_q == DIV_LAST);
  assign frame_active = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);

  assign cmd.cmd_ready = ready;
  assign cmd.busy      = (state_q != S_IDLE);
  assign cmd.done      = (state_q == S_GAP) && (gap_q == '0);
  assign spi_ncs       = !frame_active;
  assign spi_sclk      = sclk_q;
  assign spi_copi      = frame_active ? shift_q[15] : 1'b0;

  // State, shift register and counters; synchronous reset returns to an idle link
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      gap_q     <= '0;
      sclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      sclk_q    <= sclk_d;
    end
  end

  // Frame sequencing: the divider restarts at every phase change, COPI moves on SCLK falls
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    gap_d     = gap_q;
    sclk_d    = sclk_q;
    unique case (state_q)
      S_IDLE: begin
        div_d  = '0;
        gap_d  = '0;
        sclk_d = 1'b0;
        if (accept) begin
          shift_d   = {1'b1, cmd.cmd_addr, cmd.cmd_data};
          bit_cnt_d = 4'd15;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_end) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_cnt_q != 4'd0) begin
              shift_d = {shift_q[14:0], 1'b0};
            end
          end else if (bit_cnt_q == 4'd0) begin
            state_d = S_HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            sclk_d    = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_HOLD: begin
        if (div_end) begin
          state_d = S_GAP;
          div_d   = '0;
          gap_d   = '0;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_controller_tx.sv
// Self-checking bench for spi_controller_tx: one DUT at the default timing and
// one at HALF_PERIOD=1/CS_GAP=1, both compared against a frame-level model.
module tb_spi_controller_tx;

  logic clk;
  logic rst;
  logic sclk0, copi0, ncs0;
  logic sclk1, copi1, ncs1;
  int   cyc;
  int   tests;
  int   fails;

  spi_controller_tx_if if0 ();
  spi_controller_tx_if if1 ();

  spi_controller_tx #(.HALF_PERIOD(4), .CS_GAP(2)) dut0 (
    .clk(clk), .rst(rst), .cmd(if0), .spi_sclk(sclk0), .spi_copi(copi0), .spi_ncs(ncs0)
  );

  spi_controller_tx #(.HALF_PERIOD(1), .CS_GAP(1)) dut1 (
    .clk(clk), .rst(rst), .cmd(if1), .spi_sclk(sclk1), .spi_copi(copi1), .spi_ncs(ncs1)
  );

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic sclk;
    logic copi;
    logic ncs;
  } obs_t;

  typedef struct {
    logic [15:0] bits;
    int nbits;
    int timing_err;
    int stab_err;
    int ncs_low;
    int dones;
    int done_rel;
    int done_at_rise;
    int busy_err;
    int ready_err;
    int rise_cyc;
  } frame_t;

  localparam obs_t OBS_RST  = 6'b000001;
  localparam obs_t OBS_IDLE = 6'b100001;

  // Free-running clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the bench always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model: frame content and protocol timing from the frame rules
  function automatic logic [15:0] model_frame(input logic [6:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic int model_rise_rel(input int hp, input int k);
    return 1 + hp * (1 + 2 * k);
  endfunction

  function automatic int model_ncs_low(input int hp);
    return 34 * hp;
  endfunction

  function automatic int model_spacing(input int hp, input int gap);
    return 34 * hp + gap + 1;
  endfunction

  function automatic obs_t obs(input int s);
    obs_t o;
    if (s == 0) o = {if0.cmd_ready, if0.busy, if0.done, sclk0, copi0, ncs0};
    else        o = {if1.cmd_ready, if1.busy, if1.done, sclk1, copi1, ncs1};
    return o;
  endfunction

  task automatic drive_cmd(input int s, input logic v, input logic [6:0] a, input logic [7:0] d);
    if (s == 0) begin
      if0.cmd_valid = v; if0.cmd_addr = a; if0.cmd_data = d;
    end else begin
      if1.cmd_valid = v; if1.cmd_addr = a; if1.cmd_data = d;
    end
  endtask

  task automatic drive_valid(input int s, input logic v);
    if (s == 0) if0.cmd_valid = v;
    else        if1.cmd_valid = v;
  endtask

  // Present a command and return at the negedge just before the accepting edge
  task automatic send_cmd(input int s, input logic [6:0] a, input logic [7:0] d, output int t);
    drive_cmd(s, 1'b1, a, d);
    t = -1;
    for (int i = 0; i < 2000; i++) begin
      if (obs(s).ready === 1'b1) begin
        t = cyc + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Observe one frame from the cycle after accept until nCS rises (or stop_rises rises seen)
  task automatic monitor_frame(input int s, input int hp, input int stop_rises, output frame_t fr);
    obs_t o;
    logic ps, pncs, pcopi;
    int   last_chg, last_rise;
    bit   fin;
    fr = '{default: 0};
    ps = 1'b0; pncs = 1'b1; pcopi = 1'b0;
    last_chg = 0; last_rise = 0; fin = 1'b0;
    for (int rel = 1; rel <= 40 * hp + 20 && !fin; rel++) begin
      @(negedge clk);
      o = obs(s);
      if (o.copi !== pcopi) begin
        last_chg = rel;
        if (o.sclk === 1'b1) fr.stab_err++;
      end
      if (ps === 1'b0 && o.sclk === 1'b1) begin
        if (rel - last_chg < hp) fr.stab_err++;
        if (rel != model_rise_rel(hp, fr.nbits)) fr.timing_err++;
        if (fr.nbits < 16) fr.bits[15 - fr.nbits] = o.copi;
        fr.nbits++;
        last_rise = rel;
      end
      if (ps === 1'b1 && o.sclk === 1'b0 && rel != last_rise + hp) fr.timing_err++;
      if (o.ncs === 1'b0) begin
        fr.ncs_low++;
        if (o.ready !== 1'b0) fr.ready_err++;
      end
      if (o.busy !== 1'b1) fr.busy_err++;
      if (o.done === 1'b1) begin
        fr.dones++;
        fr.done_rel = rel;
        fr.done_at_rise = (o.ncs === 1'b1 && pncs === 1'b0) ? 1 : 0;
      end
      if (o.ncs === 1'b1 && pncs === 1'b0) begin
        fin = 1'b1;
        fr.rise_cyc = cyc;
      end
      if (stop_rises > 0 && fr.nbits >= stop_rises) fin = 1'b1;
      ps = o.sclk; pncs = o.ncs; pcopi = o.copi;
    end
    if (!fin) fr.nbits = -1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    drive_cmd(0, 1'b1, 7'h55, 8'hAA);
    drive_cmd(1, 1'b1, 7'h2A, 8'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        o = obs(s);
        tests++;
        if (o !== OBS_RST) begin
          fails++;
          $display("[TB] FAIL reset_hold dut%0d cycle %0d: got %b, expected %b", s, i, o, OBS_RST);
        end
      end
    end
    rst = 1'b0;
    drive_valid(0, 1'b0);
    drive_valid(1, 1'b0);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = obs(s);
      tests++;
      if (o !== OBS_IDLE) begin
        fails++;
        $display("[TB] FAIL reset_release dut%0d: got %b, expected %b", s, o, OBS_IDLE);
      end
    end
  endtask

  task automatic test_single_write();
    frame_t fr;
    int t;
    obs_t o;
    send_cmd(0, 7'h00, 8'hF0, t);
    monitor_frame(0, 4, 0, fr);
    drive_valid(0, 1'b0);
    tests++;
    if (fr.nbits !== 16 || fr.bits !== model_frame(7'h00, 8'hF0)) begin
      fails++;
      $display("[TB] FAIL single_bits: got %h (%0d bits), expected %h (16 bits)", fr.bits, fr.nbits, model_frame(7'h00, 8'hF0));
    end
    tests++;
    if (fr.ncs_low !== model_ncs_low(4)) begin
      fails++;
      $display("[TB] FAIL single_ncs_low: got %0d, expected %0d", fr.ncs_low, model_ncs_low(4));
    end
    tests++;
    if (fr.dones !== 1 || fr.done_at_rise !== 1 || fr.done_rel !== 1 + model_ncs_low(4)) begin
      fails++;
      $display("[TB] FAIL single_done: got %0d pulses at rel %0d (with rise %0d), expected 1 at rel %0d with rise 1",
               fr.dones, fr.done_rel, fr.done_at_rise, 1 + model_ncs_low(4));
    end
    tests++;
    if (fr.timing_err !== 0 || fr.stab_err !== 0) begin
      fails++;
      $display("[TB] FAIL single_timing: got %0d timing / %0d stability errors, expected 0/0", fr.timing_err, fr.stab_err);
    end
    repeat (2) @(negedge clk);
    o = obs(0);
    tests++;
    if (o !== OBS_IDLE) begin
      fails++;
      $display("[TB] FAIL single_ready_return: got %b, expected %b", o, OBS_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    int t1, t2;
    send_cmd(0, 7'h02, 8'hFF, t1);
    monitor_frame(0, 4, 0, f1);
    send_cmd(0, 7'h04, 8'h80, t2);
    monitor_frame(0, 4, 0, f2);
    drive_valid(0, 1'b0);
    tests++;
    if (t2 - t1 !== model_spacing(4, 2)) begin
      fails++;
      $display("[TB] FAIL b2b_spacing: got %0d, expected %0d", t2 - t1, model_spacing(4, 2));
    end
    tests++;
    if (t2 - f1.rise_cyc < 2) begin
      fails++;
      $display("[TB] FAIL b2b_ncs_gap: got %0d high cycles, expected >= 2", t2 - f1.rise_cyc);
    end
    tests++;
    if (f1.nbits !== 16 || f1.bits !== model_frame(7'h02, 8'hFF)) begin
      fails++;
      $display("[TB] FAIL b2b_bits1: got %h (%0d bits), expected %h", f1.bits, f1.nbits, model_frame(7'h02, 8'hFF));
    end
    tests++;
    if (f2.nbits !== 16 || f2.bits !== model_frame(7'h04, 8'h80) || f2.dones !== 1) begin
      fails++;
      $display("[TB] FAIL b2b_bits2: got %h (%0d bits, %0d done), expected %h (16 bits, 1 done)",
               f2.bits, f2.nbits, f2.dones, model_frame(7'h04, 8'h80));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_frame_changes();
    frame_t fr;
    int t;
    send_cmd(0, 7'h15, 8'h3C, t);
    fork
      monitor_frame(0, 4, 0, fr);
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          drive_cmd(0, logic'(i % 2), 7'h7F, 8'($urandom));
        end
        drive_valid(0, 1'b0);
      end
    join
    tests++;
    if (fr.nbits !== 16 || fr.bits !== model_frame(7'h15, 8'h3C)) begin
      fails++;
      $display("[TB] FAIL midframe_bits: got %h (%0d bits), expected %h", fr.bits, fr.nbits, model_frame(7'h15, 8'h3C));
    end
    tests++;
    if (fr.ready_err !== 0 || fr.busy_err !== 0 || fr.dones !== 1) begin
      fails++;
      $display("[TB] FAIL midframe_handshake: got ready_err=%0d busy_err=%0d dones=%0d, expected 0/0/1",
               fr.ready_err, fr.busy_err, fr.dones);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    frame_t fr;
    int t;
    int bad;
    obs_t o;
    logic [15:0] exp;
    send_cmd(0, 7'h2A, 8'h99, t);
    monitor_frame(0, 4, 5, fr);
    exp = model_frame(7'h2A, 8'h99);
    tests++;
    if (fr.nbits !== 5 || fr.bits[15:11] !== exp[15:11]) begin
      fails++;
      $display("[TB] FAIL rstmid_prefix: got %b (%0d bits), expected %b (5 bits)", fr.bits[15:11], fr.nbits, exp[15:11]);
    end
    rst = 1'b1;
    drive_valid(0, 1'b0);
    @(negedge clk);
    o = obs(0);
    tests++;
    if (o !== OBS_RST) begin
      fails++;
      $display("[TB] FAIL rstmid_next_cycle: got %b, expected %b", o, OBS_RST);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (obs(0) !== OBS_IDLE) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("[TB] FAIL rstmid_quiet: got %0d non-idle cycles, expected 0", bad);
    end
    send_cmd(0, 7'h01, 8'hAA, t);
    monitor_frame(0, 4, 0, fr);
    drive_valid(0, 1'b0);
    tests++;
    if (fr.nbits !== 16 || fr.bits !== model_frame(7'h01, 8'hAA) || fr.dones !== 1) begin
      fails++;
      $display("[TB] FAIL rstmid_recover: got %h (%0d bits, %0d done), expected %h (16 bits, 1 done)",
               fr.bits, fr.nbits, fr.dones, model_frame(7'h01, 8'hAA));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fast_config();
    frame_t f1, f2;
    int t1, t2;
    send_cmd(1, 7'h03, 8'h55, t1);
    monitor_frame(1, 1, 0, f1);
    send_cmd(1, 7'h03, 8'h55, t2);
    monitor_frame(1, 1, 0, f2);
    drive_valid(1, 1'b0);
    tests++;
    if (f1.nbits !== 16 || f1.bits !== model_frame(7'h03, 8'h55)) begin
      fails++;
      $display("[TB] FAIL fast_bits: got %h (%0d bits), expected %h", f1.bits, f1.nbits, model_frame(7'h03, 8'h55));
    end
    tests++;
    if (f1.ncs_low !== model_ncs_low(1) || f1.timing_err !== 0) begin
      fails++;
      $display("[TB] FAIL fast_timing: got ncs_low=%0d timing_err=%0d, expected %0d/0", f1.ncs_low, f1.timing_err, model_ncs_low(1));
    end
    tests++;
    if (t2 - t1 !== model_spacing(1, 1)) begin
      fails++;
      $display("[TB] FAIL fast_spacing: got %0d, expected %0d", t2 - t1, model_spacing(1, 1));
    end
    tests++;
    if (f2.nbits !== 16 || f2.bits !== model_frame(7'h03, 8'h55) || f2.dones !== 1) begin
      fails++;
      $display("[TB] FAIL fast_second: got %h (%0d bits, %0d done), expected %h", f2.bits, f2.nbits, f2.dones, model_frame(7'h03, 8'h55));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random_writes();
    frame_t fr;
    int t, s, hp, gap;
    logic [6:0] a;
    logic [7:0] d;
    obs_t o;
    for (int i = 0; i < 8; i++) begin
      s   = i % 2;
      hp  = (s == 0) ? 4 : 1;
      gap = (s == 0) ? 2 : 1;
      a   = 7'($urandom_range(0, 127));
      d   = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_cmd(s, a, d, t);
      monitor_frame(s, hp, 0, fr);
      drive_valid(s, 1'b0);
      tests++;
      if (fr.nbits !== 16 || fr.bits !== model_frame(a, d) || fr.ncs_low !== model_ncs_low(hp)) begin
        fails++;
        $display("[TB] FAIL random_frame dut%0d: got %h (%0d bits, ncs_low %0d), expected %h (16 bits, ncs_low %0d)",
                 s, fr.bits, fr.nbits, fr.ncs_low, model_frame(a, d), model_ncs_low(hp));
      end
      tests++;
      if (fr.dones !== 1 || fr.done_at_rise !== 1 || fr.timing_err !== 0 || fr.stab_err !== 0 ||
          fr.busy_err !== 0 || fr.ready_err !== 0) begin
        fails++;
        $display("[TB] FAIL random_protocol dut%0d: got dones=%0d at_rise=%0d timing=%0d stab=%0d busy=%0d ready=%0d, expected 1/1/0/0/0/0",
                 s, fr.dones, fr.done_at_rise, fr.timing_err, fr.stab_err, fr.busy_err, fr.ready_err);
      end
      repeat (gap) @(negedge clk);
      o = obs(s);
      tests++;
      if (o !== OBS_IDLE) begin
        fails++;
        $display("[TB] FAIL random_ready dut%0d: got %b, expected %b", s, o, OBS_IDLE);
      end
    end
  endtask

  // Run every scenario in sequence and print the summary
  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    drive_cmd(0, 1'b0, 7'h00, 8'h00);
    drive_cmd(1, 1'b0, 7'h00, 8'h00);
    test_reset();
    test_single_write();
    test_back_to_back();
    test_mid_frame_changes();
    test_reset_mid_frame();
    test_fast_config();
    test_random_writes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
